// File: rtl/chip8_timer_ctrl_if.sv
// CPU-side timer access bus for chip8_timer_ctrl: level request, opcode,
// write data, one-cycle completion strobe and held read data.
interface chip8_timer_ctrl_if;
    logic       cpu_req;
    logic [1:0] cpu_op;
    logic [7:0] cpu_wdata;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;

    modport master (
        output cpu_req,
        output cpu_op,
        output cpu_wdata,
        input  cpu_ack,
        input  cpu_rdata
    );

    modport slave (
        input  cpu_req,
        input  cpu_op,
        input  cpu_wdata,
        output cpu_ack,
        output cpu_rdata
    );
endinterface

// File: rtl/chip8_timer_ctrl.sv
// CHIP-8 delay/sound timers on a 60 Hz prescaler with a 3-state CPU access FSM.
// Optional macro CHIP8_TIMER_HALT_EN adds a halt input that freezes the timebase.
module chip8_timer_ctrl #(
    parameter int unsigned DIVISOR = 833333
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef CHIP8_TIMER_HALT_EN
    input  logic              halt,
`endif
    chip8_timer_ctrl_if.slave cpu,
    output logic              tick_60,
    output logic              dt_active,
    output logic              sound_on
);

    localparam int unsigned   CW   = $clog2(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ACK
    } state_t;

    typedef enum logic [1:0] {
        OP_RD_DT = 2'b00,
        OP_WR_DT = 2'b01,
        OP_WR_ST = 2'b10,
        OP_RD_ST = 2'b11
    } op_t;

    state_t        r_state;
    op_t           r_op;
    logic [7:0]    r_wdata;
    logic [7:0]    r_rdata;
    logic          r_ack;
    logic [CW-1:0] r_presc;
    logic [7:0]    r_dt;
    logic [7:0]    r_st;
    logic          r_dt_act;
    logic          r_snd;

    logic          w_halt;
    logic          w_tick;
    logic          w_exec;
    logic          w_wr_dt;
    logic          w_wr_st;

`ifdef CHIP8_TIMER_HALT_EN
    assign w_halt = halt;
`else
    assign w_halt = 1'b0;
`endif

    assign w_tick  = (r_presc == LAST) && !w_halt;
    assign w_exec  = (r_state == S_EXEC);
    assign w_wr_dt = w_exec && (r_op == OP_WR_DT);
    assign w_wr_st = w_exec && (r_op == OP_WR_ST);

    // Free-running timebase; only halt can stall it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (!w_halt) begin
            if (r_presc == LAST) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + CW'(1);
            end
        end
    end

    // A CPU write to a timer wins over a coincident tick decrement of that timer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dt <= '0;
            r_st <= '0;
        end else begin
            if (w_wr_dt) begin
                r_dt <= r_wdata;
            end else if (w_tick && (r_dt != '0)) begin
                r_dt <= r_dt - 8'd1;
            end

            if (w_wr_st) begin
                r_st <= r_wdata;
            end else if (w_tick && (r_st != '0)) begin
                r_st <= r_st - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_RD_DT;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu.cpu_req) begin
                        r_op    <= op_t'(cpu.cpu_op);
                        r_wdata <= cpu.cpu_wdata;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Reads see the pre-edge timer value, i.e. before any tick decrement.
                    if (r_op == OP_RD_DT) begin
                        r_rdata <= r_dt;
                    end else if (r_op == OP_RD_ST) begin
                        r_rdata <= r_st;
                    end
                    r_ack   <= 1'b1;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dt_act <= 1'b0;
            r_snd    <= 1'b0;
        end else begin
            r_dt_act <= (r_dt != '0);
            r_snd    <= (r_st != '0);
        end
    end

    assign tick_60       = w_tick;
    assign dt_active     = r_dt_act;
    assign sound_on      = r_snd;
    assign cpu.cpu_ack   = r_ack;
    assign cpu.cpu_rdata = r_rdata;

endmodule

// File: doc/chip8_timer_ctrl.md
CHIP8_TIMER_CTRL -- requirements
Module: chip8_timer_ctrl

Interface
REQ-001 SHALL have parameter DIVISOR, default 833333, clk cycles per 60 Hz tick (50 MHz / 60); legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz; sole clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cpu_req  input  1  CPU timer-access request, level.
REQ-005 SHALL have port cpu_op  input  2  00 read DT, 01 write DT, 10 write ST, 11 read ST.
REQ-006 SHALL have port cpu_wdata  input  8  write data.
REQ-007 SHALL have port cpu_ack  output  1  one-cycle completion pulse.
REQ-008 SHALL have port cpu_rdata  output  8  read data, valid while cpu_ack=1, held until next read.
REQ-009 SHALL have port tick_60  output  1  one-cycle 60 Hz strobe.
REQ-010 SHALL have port dt_active  output  1  delay timer nonzero.
REQ-011 SHALL have port sound_on  output  1  sound timer nonzero (buzzer enable).

Function
REQ-012 SHALL hold prescaler counting 0..DIVISOR-1, wrapping to 0; tick_60 SHALL be 1 in exactly the cycle the count equals DIVISOR-1.
REQ-013 SHALL hold 8-bit registers DT and ST; on each tick_60 cycle each nonzero register SHALL decrement by 1 at that edge; a zero register SHALL stay 0 (no wrap to 255).
REQ-014 SHALL sequence CPU access with FSM IDLE -> EXEC -> ACK -> IDLE; IDLE->EXEC when cpu_req=1 (latching cpu_op, cpu_wdata); EXEC->ACK unconditionally; ACK->IDLE unconditionally.
REQ-015 SHALL, at the edge ending EXEC, load the write target from latched data, or capture the read target's pre-edge value into cpu_rdata.
REQ-016 SHALL assert cpu_ack only in ACK; latency from request-sampling edge to cpu_ack high is 2 cycles.
REQ-017 SHALL ignore cpu_req in EXEC and ACK; a request still high in ACK is re-accepted in the following IDLE cycle.
REQ-018 SHALL, when a write and tick_60 hit the same timer in one cycle, apply the write and drop that decrement; the other timer still decrements.
REQ-019 SHALL, on read coincident with tick_60, return the pre-decrement value.
REQ-020 SHALL register dt_active = (DT != 0) and sound_on = (ST != 0), each lagging its register by one cycle.
REQ-021 SHALL keep the prescaler free-running, unaffected by CPU traffic.

Reset
REQ-022 SHALL, while reset_n=0, force prescaler=0, DT=0, ST=0, FSM=IDLE, cpu_ack=0, cpu_rdata=0, tick_60=0, dt_active=0, sound_on=0.
REQ-023 SHALL, on reset mid-transaction, abandon it with no cpu_ack and no register write.
REQ-024 SHALL emit first tick_60 exactly DIVISOR cycles after reset_n deassertion edge sampling.

Configuration
REQ-025 SHALL, with macro CHIP8_TIMER_HALT_EN defined, add port halt  input  1; while halt=1 the prescaler holds, tick_60 stays 0, DT/ST do not decrement, CPU access still completes normally.
REQ-026 SHALL, without CHIP8_TIMER_HALT_EN, have no halt port and behave as if halt=0.

Verification (DIVISOR=4)
REQ-027 SHALL cover: reset release, no requests -> tick_60 high cycles 3, 7, 11; all other outputs 0.
REQ-028 SHALL cover: write DT=3 -> cpu_ack 2 cycles after request, dt_active high next cycle, DT 3->2->1->0 over three ticks, then stays 0, dt_active falls.
REQ-029 SHALL cover: write ST=5 timed so EXEC coincides with tick_60 -> ST=5 (not 4); sound_on high for exactly 5 further ticks.
REQ-030 SHALL cover: DT=2, read DT in tick cycle -> cpu_rdata=2, DT=1 afterwards.
REQ-031 SHALL cover: reset_n pulsed low during EXEC of write ST=9 -> no cpu_ack, ST=0, sound_on=0.
REQ-032 SHALL cover (HALT_EN): DT=4, halt=1 for 20 cycles -> no tick_60, DT stays 4; after release DT decrements per tick.
